// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline types, states and control presets for hazard handling
package riscv_pipe_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, ERR = 2'd2} state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exdm_en;
    logic dmwb_bubble;
  } pipe_ctrl_t;
  localparam pipe_ctrl_t CTRL_NORMAL  = pipe_ctrl_t'(7'b1101010);
  localparam pipe_ctrl_t CTRL_HOLD    = pipe_ctrl_t'(7'b0000001);
  localparam pipe_ctrl_t CTRL_FLUSH   = pipe_ctrl_t'(7'b1111110);
  localparam pipe_ctrl_t CTRL_LOADUSE = pipe_ctrl_t'(7'b0001110);
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use comparator between the EX load destination and ID sources
module hazard_detect
  import riscv_pipe_pkg::*;
(
  input  logic       rs1Used_id,
  input  logic       rs2Used_id,
  input  logic [4:0] rs1Addr_id,
  input  logic [4:0] rs2Addr_id,
  input  logic       MemRead_ex,
  input  logic [4:0] rdAddr_ex,
  output logic       loaduse
);
  // a load writing x0 never creates a dependency
  always_comb
    loaduse = MemRead_ex && rdAddr_ex != REG_ZERO &&
              ((rs1Used_id && rs1Addr_id == rdAddr_ex) || (rs2Used_id && rs2Addr_id == rdAddr_ex));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer with memory-wait timeout and stall-cycle counter
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1Addr_id,
  input  logic [4:0]       rs2Addr_id,
  input  logic             rs1Used_id,
  input  logic             rs2Used_id,
  input  logic             MemRead_ex,
  input  logic [4:0]       rdAddr_ex,
  input  logic             BranchTaken_ex,
  input  logic             MemAccess_mem,
  input  logic             MemReady,
  output logic             PC_en,
  output logic             IFID_en,
  output logic             IFID_flush,
  output logic             IDEX_en,
  output logic             IDEX_flush,
  output logic             EXDM_en,
  output logic             DMWB_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WW = $clog2(TIMEOUT) + 1;
  state_e           r_state;
  logic [WW-1:0]    r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_loaduse;
  logic             w_memstall;
  pipe_ctrl_t       w_ctrl;

  hazard_detect u_hazard_detect (
    .rs1Used_id (rs1Used_id),
    .rs2Used_id (rs2Used_id),
    .rs1Addr_id (rs1Addr_id),
    .rs2Addr_id (rs2Addr_id),
    .MemRead_ex (MemRead_ex),
    .rdAddr_ex  (rdAddr_ex),
    .loaduse    (w_loaduse)
  );

  assign w_memstall = MemAccess_mem & ~MemReady;

  // priority mux: a memory wait freezes everything, a taken branch flushes the dependent op
  always_comb
    w_ctrl = !rst_n ? CTRL_NORMAL :
             (r_state == ERR || w_memstall) ? CTRL_HOLD :
             BranchTaken_ex ? CTRL_FLUSH :
             w_loaduse ? CTRL_LOADUSE : CTRL_NORMAL;

  // state sequencing, wait-cycle timeout and stall-cycle accounting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (!w_ctrl.pc_en) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      case (r_state)
        RUN: if (w_memstall) begin
          r_state    <= MEMWAIT;
          r_wait_cnt <= WW'(1);
        end
        MEMWAIT: if (!w_memstall) begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end else if (r_wait_cnt == WW'(TIMEOUT - 1)) r_state <= ERR;
        else r_wait_cnt <= r_wait_cnt + WW'(1);
        default: r_state <= ERR;
      endcase
    end
  end

  assign {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXDM_en, DMWB_bubble} = w_ctrl;
  assign mem_err   = r_state == ERR;
  assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stall/flush priority, timeout and counter wrap
module tb_pipe_hazard_ctrl;
  localparam logic [6:0] NORMAL  = 7'b1101010;
  localparam logic [6:0] HOLD    = 7'b0000001;
  localparam logic [6:0] FLUSH   = 7'b1111110;
  localparam logic [6:0] LOADUSE = 7'b0001110;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1Addr_id, rs2Addr_id, rdAddr_ex;
  logic       rs1Used_id, rs2Used_id, MemRead_ex, BranchTaken_ex, MemAccess_mem, MemReady;
  logic       PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXDM_en, DMWB_bubble, mem_err;
  logic [3:0] stall_cnt;
  logic [3:0] exp_cnt;
  int         n_chk = 0;
  int         n_pass = 0;

  pipe_hazard_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
    .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
    .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
    .BranchTaken_ex(BranchTaken_ex), .MemAccess_mem(MemAccess_mem), .MemReady(MemReady),
    .PC_en(PC_en), .IFID_en(IFID_en), .IFID_flush(IFID_flush),
    .IDEX_en(IDEX_en), .IDEX_flush(IDEX_flush), .EXDM_en(EXDM_en),
    .DMWB_bubble(DMWB_bubble), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // entered just after a falling edge with inputs set; leaves at the next falling edge
  task automatic cyc(input string tag, input logic [6:0] exp_ctrl, input logic [3:0] exp_stall);
    #1 chk({tag, "_ctrl"}, {PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXDM_en, DMWB_bubble}, exp_ctrl);
    @(posedge clk);
    #1 chk({tag, "_cnt"}, stall_cnt, exp_stall);
    @(negedge clk);
  endtask

  task automatic clr();
    {rs1Addr_id, rs2Addr_id, rdAddr_ex} = '0;
    {rs1Used_id, rs2Used_id, MemRead_ex, BranchTaken_ex, MemAccess_mem, MemReady} = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    repeat (2) @(negedge clk);
    MemAccess_mem = 1'b1;
    cyc("rst", NORMAL, 4'd0);
    chk("rst_err", mem_err, 1'b0);
    rst_n = 1'b1;
    clr();
    cyc("idle", NORMAL, 4'd0);
    MemRead_ex = 1'b1; rdAddr_ex = 5'd5; rs1Addr_id = 5'd5; rs1Used_id = 1'b1;
    cyc("lu_rs1", LOADUSE, 4'd1);
    MemRead_ex = 1'b0;
    cyc("lu_after", NORMAL, 4'd1);
    clr();
    MemRead_ex = 1'b1; rdAddr_ex = 5'd7; rs2Addr_id = 5'd7; rs2Used_id = 1'b1;
    cyc("lu_rs2", LOADUSE, 4'd2);
    rs2Used_id = 1'b0;
    cyc("lu_unused", NORMAL, 4'd2);
    clr();
    MemRead_ex = 1'b1; rdAddr_ex = 5'd0; rs1Addr_id = 5'd0; rs1Used_id = 1'b1;
    cyc("lu_x0", NORMAL, 4'd2);
    rdAddr_ex = 5'd9; rs1Addr_id = 5'd9; BranchTaken_ex = 1'b1;
    cyc("br_over_lu", FLUSH, 4'd2);
    clr();
    MemAccess_mem = 1'b1;
    exp_cnt = 4'd2;
    for (int i = 0; i < 3; i++) begin
      exp_cnt++;
      cyc("memwait", HOLD, exp_cnt);
    end
    MemReady = 1'b1;
    cyc("mem_ready", NORMAL, 4'd5);
    MemReady = 1'b0; BranchTaken_ex = 1'b1;
    cyc("br_mask1", HOLD, 4'd6);
    cyc("br_mask2", HOLD, 4'd7);
    MemReady = 1'b1;
    cyc("br_on_ready", FLUSH, 4'd7);
    clr();
    MemAccess_mem = 1'b1;
    exp_cnt = 4'd7;
    for (int i = 0; i < 15; i++) begin
      exp_cnt++;
      cyc("wait15", HOLD, exp_cnt);
    end
    MemReady = 1'b1;
    cyc("ready_16th", NORMAL, 4'd6);
    chk("ready_16th_err", mem_err, 1'b0);
    MemReady = 1'b0;
    exp_cnt = 4'd6;
    for (int i = 0; i < 16; i++) begin
      exp_cnt++;
      cyc("timeout", HOLD, exp_cnt);
      chk("timeout_err", mem_err, i == 15);
    end
    clr();
    MemReady = 1'b1;
    cyc("err_hold", HOLD, 4'd7);
    chk("err_sticky", mem_err, 1'b1);
    rst_n = 1'b0;
    cyc("err_rst", NORMAL, 4'd0);
    chk("err_rst_err", mem_err, 1'b0);
    rst_n = 1'b1;
    clr();
    cyc("post_rst", NORMAL, 4'd0);
    MemRead_ex = 1'b1; rdAddr_ex = 5'd3; rs2Addr_id = 5'd3; rs2Used_id = 1'b1;
    for (int i = 0; i < 16; i++) @(negedge clk);
    cyc("wrap", LOADUSE, 4'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. It detects load-use hazards, taken-branch redirects and multi-cycle data-memory waits, and drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/DM and DM/WB pipeline registers. It also keeps a stall-cycle performance counter and a sticky memory-timeout error.

Parameters:
TIMEOUT, 16, maximum consecutive memory-wait cycles before error (>=2)
CNT_W, 32, stall counter width

Ports:
clk  in  1  pipeline clock
rst_n  in  1  synchronous active-low reset
rs1Addr_id  in  5  rs1 of instruction in ID
rs2Addr_id  in  5  rs2 of instruction in ID
rs1Used_id  in  1  ID instruction reads rs1
rs2Used_id  in  1  ID instruction reads rs2
MemRead_ex  in  1  EX instruction is a load
rdAddr_ex  in  5  destination of EX instruction
BranchTaken_ex  in  1  EX resolved a taken branch/jump
MemAccess_mem  in  1  MEM-stage instruction accesses data memory
MemReady  in  1  data memory completes access this cycle
PC_en  out  1  PC register load enable
IFID_en  out  1  IF/ID enable
IFID_flush  out  1  IF/ID loads NOP
IDEX_en  out  1  ID/EX enable
IDEX_flush  out  1  ID/EX loads bubble (all control zero)
EXDM_en  out  1  EX/DM enable
DMWB_bubble  out  1  DM/WB captures RegWrite=0, MemtoReg=0
mem_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  count of cycles with PC_en=0

Behaviour:
- States: RUN, MEMWAIT, ERR. On reset: state=RUN, wait_cnt=0, stall_cnt=0, mem_err=0.
- Outputs are combinational from state and inputs. The "normal" output set is: all enables=1, flushes=0, DMWB_bubble=0.
- During reset (rst_n=0), outputs take the normal set.
- memstall = MemAccess_mem & ~MemReady.
- loaduse = MemRead_ex & rdAddr_ex!=0 & ((rs1Used_id & rs1Addr_id==rdAddr_ex) | (rs2Used_id & rs2Addr_id==rdAddr_ex)).
- Priority in RUN/MEMWAIT: memstall > BranchTaken_ex > loaduse.
  - memstall: PC_en=IFID_en=IDEX_en=EXDM_en=0, DMWB_bubble=1, no flushes. A branch held in EX is re-evaluated after the stall.
  - BranchTaken_ex (no memstall): PC_en=1, IFID_flush=1, IDEX_flush=1. The load-use check is suppressed because the dependent instruction is flushed.
  - loaduse only: PC_en=0, IFID_en=0, IDEX_flush=1, EXDM_en=1. This gives exactly one bubble. The next cycle the load is in MEM, so loaduse deasserts.
  - none: normal set.
- Transitions:
  - RUN -> MEMWAIT when memstall; wait_cnt<=1.
  - MEMWAIT stays while memstall; wait_cnt increments.
  - MEMWAIT -> RUN on MemReady=1 (that cycle uses the normal priority rules); wait_cnt<=0.
  - MEMWAIT -> ERR when memstall and wait_cnt==TIMEOUT-1. A ready on the TIMEOUT-th cycle is still accepted.
  - ERR: all enables 0, DMWB_bubble=1, mem_err=1. Exit only by reset.
- stall_cnt increments each cycle PC_en=0 (including ERR) and wraps modulo 2^CNT_W.
- A zero-register destination never causes a load-use stall.
- Reset in MEMWAIT or ERR returns to RUN next edge regardless of MemReady.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - state enum (RUN=2'd0, MEMWAIT=2'd1, ERR=2'd2)
  - REG_ZERO=5'd0
  - the pipeline-control bundle typedef (en/flush per stage)
- One sub-module, hazard_detect, holds the pure combinational loaduse comparator. It is reused by the forwarding unit tests.
- FSM, counters and priority mux stay in the top module.

Test Plan:
- Load-use: MemRead_ex=1, rdAddr_ex=5, rs1Addr_id=5, rs1Used_id=1 -> one cycle PC_en=0, IFID_en=0, IDEX_flush=1; stall_cnt 0->1. rdAddr_ex=0 with the same inputs -> no stall.
- Branch over load-use: BranchTaken_ex=1 while loaduse is true -> PC_en=1, IFID_flush=1, IDEX_flush=1; stall_cnt unchanged.
- Memory wait: MemAccess_mem=1, MemReady=0 for 3 cycles then 1 -> 3 cycles all enables 0 with DMWB_bubble=1, then normal set; stall_cnt=3; state RUN.
- Mem stall masks branch: BranchTaken_ex=1 during memstall -> no flush until MemReady=1. The flush occurs on the ready cycle.
- Timeout: TIMEOUT=16, MemReady held 0 -> ERR entered after cycle 16, mem_err=1 persists. Asserting rst_n=0 for one edge clears mem_err, stall_cnt and state.
- Counter wrap: CNT_W=4, 17 stall cycles -> stall_cnt=1.
